// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: operand forwarding, load-use stall and branch flush
// control for the in-order RV32 pipeline. Optional macro: HAZARD_PERF_EN.
module pipe_hazard_unit #(
    parameter int PIPE_DEPTH   = 3,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int SELW         = $clog2(PIPE_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  logic [4:0]      id_rd,
    input  logic            id_we,
    input  logic            id_is_load,
    input  logic            ex_br_taken,
    output logic            stall,
    output logic            flush,
    output logic            issue,
    output logic [SELW-1:0] fwd_a_sel,
    output logic [SELW-1:0] fwd_b_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_fwd_cnt
`endif
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    logic [PIPE_DEPTH-1:0] r_vld;
    logic [PIPE_DEPTH-1:0] r_we;
    logic [PIPE_DEPTH-1:0] r_ld;
    logic [4:0]            r_rd [PIPE_DEPTH];
    logic [CW-1:0]         r_cnt;

    logic            w_flush;
    logic            w_stall;
    logic            w_issue;
    logic [SELW-1:0] w_a_sel;
    logic [SELW-1:0] w_b_sel;
    logic            w_a_ldu;
    logic            w_b_ldu;

    // Youngest producer per operand: scan oldest first so the smallest
    // matching index is the one left standing.
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        w_a_ldu = 1'b0;
        w_b_ldu = 1'b0;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            if (r_vld[k] && r_we[k] && r_rd[k] != 5'd0) begin
                if (id_rs1_used && r_rd[k] == id_rs1) begin
                    w_a_sel = SELW'(k + 1);
                    w_a_ldu = r_ld[k] && (k < LOAD_LAT);
                end
                if (id_rs2_used && r_rd[k] == id_rs2) begin
                    w_b_sel = SELW'(k + 1);
                    w_b_ldu = r_ld[k] && (k < LOAD_LAT);
                end
            end
        end
    end

    assign w_flush = ex_br_taken | (r_cnt != '0);
    assign w_stall = id_valid & (w_a_ldu | w_b_ldu) & ~w_flush;
    assign w_issue = id_valid & ~w_stall & ~w_flush;

    assign stall     = w_stall;
    assign flush     = w_flush;
    assign issue     = w_issue;
    assign fwd_a_sel = w_a_sel;
    assign fwd_b_sel = w_b_sel;

    // Tracked stages always advance; entry 0 takes the issued op or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_we  <= '0;
            r_ld  <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                r_rd[k] <= 5'd0;
            end
        end else begin
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_we[k]  <= r_we[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_vld[0] <= w_issue;
            r_we[0]  <= w_issue & id_we;
            r_ld[0]  <= w_issue & id_is_load;
            r_rd[0]  <= w_issue ? id_rd : 5'd0;
        end
    end

    // Flush window: a taken branch (re)starts the countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (ex_br_taken) begin
            r_cnt <= CW'(FLUSH_CYCLES - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_fwd;
    logic        w_fwd_hit;

    assign w_fwd_hit = w_issue & ((w_a_sel != '0) | (w_b_sel != '0));

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_fwd   <= '0;
        end else begin
            if (w_stall && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 1'b1;
            if (w_flush && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + 1'b1;
            if (w_fwd_hit && r_perf_fwd != '1)
                r_perf_fwd <= r_perf_fwd + 1'b1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_fwd_cnt   = r_perf_fwd;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed vector table plus randomized run
// against a queue-based reference model (default parameters).
module tb_pipe_hazard_unit;
    localparam int D   = 3;
    localparam int LL  = 1;
    localparam int FC  = 2;
    localparam int SW  = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs1;
    logic [4:0]    id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [4:0]    id_rd;
    logic          id_we;
    logic          id_is_load;
    logic          ex_br_taken;
    logic          stall;
    logic          flush;
    logic          issue;
    logic [SW-1:0] fwd_a_sel;
    logic [SW-1:0] fwd_b_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_flush_cnt;
    logic [31:0]   perf_fwd_cnt;
`endif

    always #5 clk = ~clk;

    pipe_hazard_unit #(
        .PIPE_DEPTH(D), .LOAD_LAT(LL), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_br_taken(ex_br_taken), .stall(stall), .flush(flush),
        .issue(issue), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt),
        .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    typedef struct packed {
        bit       r;
        bit       v;
        bit [4:0] rs1;
        bit       u1;
        bit [4:0] rs2;
        bit       u2;
        bit [4:0] rd;
        bit       we;
        bit       ld;
        bit       br;
    } vin_t;

    typedef struct {
        vin_t i;
        int   st;
        int   fl;
        int   is;
        int   a;
        int   b;
    } row_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       we;
        bit       ld;
    } ent_t;

    int   checks = 0;
    int   fails  = 0;
    row_t tbl[$];

    // Reference model: queue of issued ops by age, flush as an end-cycle.
    ent_t q[$];
    int   cyc;
    int   flush_end;

    function automatic vin_t mk(bit r, bit v, int rs1, bit u1, int rs2,
                                bit u2, int rd, bit we, bit ld, bit br);
        vin_t x;
        x.r = r; x.v = v; x.rs1 = 5'(rs1); x.u1 = u1;
        x.rs2 = 5'(rs2); x.u2 = u2; x.rd = 5'(rd);
        x.we = we; x.ld = ld; x.br = br;
        return x;
    endfunction

    function automatic vin_t wr(int rd);
        return mk(0, 1, 0, 0, 0, 0, rd, 1, 0, 0);
    endfunction

    function automatic vin_t bub();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vin_t rd1(int r);
        return mk(0, 1, r, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic row(vin_t x, int st, int fl, int is, int a, int b);
        row_t t;
        t.i = x; t.st = st; t.fl = fl; t.is = is; t.a = a; t.b = b;
        tbl.push_back(t);
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic apply(vin_t x);
        @(negedge clk);
        rst = x.r; id_valid = x.v;
        id_rs1 = x.rs1; id_rs1_used = x.u1;
        id_rs2 = x.rs2; id_rs2_used = x.u2;
        id_rd = x.rd; id_we = x.we; id_is_load = x.ld;
        ex_br_taken = x.br;
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < D; i++) q.push_back('{0, 5'd0, 0, 0});
        flush_end = 0;
        cyc = 0;
    endtask

    task automatic model_eval(vin_t x, output int st, output int fl,
                              output int is, output int a, output int b);
        bit la;
        bit lb;
        a = 0; b = 0; la = 0; lb = 0;
        fl = (x.br || cyc < flush_end) ? 1 : 0;
        for (int i = 0; i < D; i++) begin
            if (q[i].v && q[i].we && q[i].rd != 0) begin
                if (a == 0 && x.u1 && q[i].rd == x.rs1) begin
                    a = i + 1; la = q[i].ld && i < LL;
                end
                if (b == 0 && x.u2 && q[i].rd == x.rs2) begin
                    b = i + 1; lb = q[i].ld && i < LL;
                end
            end
        end
        st = (x.v && (la || lb) && fl == 0) ? 1 : 0;
        is = (x.v && st == 0 && fl == 0) ? 1 : 0;
    endtask

    task automatic model_step(vin_t x, int is);
        if (x.r) begin
            model_reset();
        end else begin
            void'(q.pop_back());
            q.push_front('{is != 0, x.rd, x.we, x.ld});
            if (x.br) flush_end = cyc + FC;
            cyc++;
        end
    endtask

    initial begin
        int st, fl, is, a, b;
        vin_t x;

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0);
        row(wr(5), 0, 0, 1, 0, 0);
        row(rd1(5), 0, 0, 1, 1, 0);
        row(wr(5), 0, 0, 1, 0, 0);
        row(bub(), 0, 0, 0, 0, 0);
        row(rd1(5), 0, 0, 1, 2, 0);
        row(wr(5), 0, 0, 1, 0, 0);
        row(bub(), 0, 0, 0, 0, 0);
        row(bub(), 0, 0, 0, 0, 0);
        row(rd1(5), 0, 0, 1, 3, 0);
        row(wr(5), 0, 0, 1, 0, 0);
        row(bub(), 0, 0, 0, 0, 0);
        row(bub(), 0, 0, 0, 0, 0);
        row(bub(), 0, 0, 0, 0, 0);
        row(mk(0, 1, 5, 1, 5, 1, 0, 0, 0, 0), 0, 0, 1, 0, 0);
        row(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0), 0, 0, 1, 0, 0);
        row(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0), 1, 0, 0, 0, 1);
        row(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0), 0, 0, 1, 0, 2);
        row(wr(0), 0, 0, 1, 0, 0);
        row(rd1(0), 0, 0, 1, 0, 0);
        row(wr(9), 0, 0, 1, 0, 0);
        row(wr(9), 0, 0, 1, 0, 0);
        row(rd1(9), 0, 0, 1, 1, 0);
        row(mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 1), 0, 1, 0, 2, 0);
        row(rd1(9), 0, 1, 0, 3, 0);
        row(rd1(9), 0, 0, 1, 0, 0);
        row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 0, 1, 0, 0, 0);
        row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1), 0, 1, 0, 0, 0);
        row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0);
        row(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0);
        row(mk(0, 1, 0, 0, 0, 0, 7, 1, 1, 0), 0, 0, 1, 0, 0);
        row(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 1), 0, 1, 0, 0, 1);
        row(bub(), 0, 1, 0, 0, 0);
        row(wr(1), 0, 0, 1, 0, 0);
        row(wr(2), 0, 0, 1, 0, 0);
        row(wr(3), 0, 0, 1, 0, 0);
        row(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
        row(mk(0, 1, 3, 1, 2, 1, 0, 0, 0, 0), 0, 0, 1, 0, 0);

        foreach (tbl[n]) begin
            apply(tbl[n].i);
            chk($sformatf("row%0d.stall", n), int'(stall), tbl[n].st);
            chk($sformatf("row%0d.flush", n), int'(flush), tbl[n].fl);
            chk($sformatf("row%0d.issue", n), int'(issue), tbl[n].is);
            chk($sformatf("row%0d.fwd_a", n), int'(fwd_a_sel), tbl[n].a);
            chk($sformatf("row%0d.fwd_b", n), int'(fwd_b_sel), tbl[n].b);
`ifdef HAZARD_PERF_EN
            if (n == tbl.size() - 1) begin
                chk("perf_stall_rst", int'(perf_stall_cnt), 0);
                chk("perf_flush_rst", int'(perf_flush_cnt), 0);
                chk("perf_fwd_rst", int'(perf_fwd_cnt), 0);
            end
`endif
        end

        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();

        for (int n = 0; n < 600; n++) begin
            x.r   = ($urandom_range(0, 59) == 0);
            x.v   = ($urandom_range(0, 3) != 0);
            x.rs1 = 5'($urandom_range(0, 6));
            x.rs2 = 5'($urandom_range(0, 6));
            x.u1  = 1'($urandom_range(0, 1));
            x.u2  = 1'($urandom_range(0, 1));
            x.rd  = 5'($urandom_range(0, 6));
            x.we  = ($urandom_range(0, 3) != 0);
            x.ld  = ($urandom_range(0, 2) == 0);
            x.br  = !x.r && ($urandom_range(0, 9) == 0);
            apply(x);
            model_eval(x, st, fl, is, a, b);
            chk("rnd.stall", int'(stall), st);
            chk("rnd.flush", int'(flush), fl);
            chk("rnd.issue", int'(issue), is);
            chk("rnd.fwd_a", int'(fwd_a_sel), a);
            chk("rnd.fwd_b", int'(fwd_b_sel), b);
            model_step(x, is);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
